c2f_chunk_reader: RTL and testbench

Consumer stage for the CPU->FPGA burst pipe. The CPU writes whole chunks into the C2F RAM ring through tlp_xcvr, then advances a chunk write pointer. This block reads each completed chunk out of that RAM in order and presents it as a 64-bit valid/ready stream to application logic. When a chunk has been fully consumed, it advances its read pointer and pulses an acknowledge so the host can reuse the slot.

---
 rtl/tlp_xcvr_pkg.sv | 26 ++
 rtl/c2f_skid2.sv | 55 +++++
 rtl/c2f_chunk_reader.sv | 141 ++++++++++++++
 tb/tb_c2f_chunk_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_xcvr_pkg.sv
// Shared C2F ring geometry, address types and the beat record used by the chunk reader.
package tlp_xcvr_pkg;

   localparam int C2F_CHUNK_QW_NBITS  = 4;
   localparam int C2F_NUMCHUNKS_NBITS = 2;

   typedef logic [63:0] uint64;

   typedef logic [C2F_NUMCHUNKS_NBITS-1:0]                    C2FChunkPtr;
   typedef logic [C2F_CHUNK_QW_NBITS-1:0]                     C2FChunkOffset;
   typedef logic [C2F_NUMCHUNKS_NBITS+C2F_CHUNK_QW_NBITS-1:0] C2FAddr;

   // One returned qword plus its chunk-boundary tags
   typedef struct packed {
      uint64 data;
      logic  sop;
      logic  eop;
   } C2FBeat;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN
   } C2FReaderState;

endpackage

// File: rtl/c2f_skid2.sv
// Two-entry FIFO of C2F beats; entry0 is always the head so it stays put while stalled.
module c2f_skid2
   import tlp_xcvr_pkg::*;
(
   input  logic       clk_in,
   input  logic       rstn_in,
   input  logic       push,
   input  C2FBeat     pushBeat,
   input  logic       pop,
   output logic [1:0] occupancy,
   output C2FBeat     head
);

   C2FBeat     entry0;
   C2FBeat     entry1;
   logic [1:0] count;

   assign occupancy = count;
   assign head      = entry0;

   // Shift-style FIFO: pops move entry1 forward, pushes land in the first free slot
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         count  <= 2'd0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  entry0 <= pushBeat;
               end else begin
                  entry1 <= pushBeat;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               entry0 <= entry1;
               count  <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  entry0 <= entry1;
                  entry1 <= pushBeat;
               end else begin
                  entry0 <= pushBeat;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/c2f_chunk_reader.sv
// Reads completed chunks out of the C2F RAM ring in order and streams them as 64-bit beats.
module c2f_chunk_reader
   import tlp_xcvr_pkg::*;
#(
   parameter int CHUNK_QW_NBITS  = C2F_CHUNK_QW_NBITS,
   parameter int NUMCHUNKS_NBITS = C2F_NUMCHUNKS_NBITS
) (
   input  logic                                clk_in,
   input  logic                                rstn_in,
   input  logic                                enable_in,
   input  logic [NUMCHUNKS_NBITS-1:0]          wrPtr_in,
   output logic [NUMCHUNKS_NBITS-1:0]          rdPtr_out,
   output logic                                dtAck_out,
   output logic [NUMCHUNKS_NBITS+CHUNK_QW_NBITS-1:0] ramAddr_out,
   input  logic [63:0]                         ramData_in,
   output logic [63:0]                         data_out,
   output logic                                valid_out,
   input  logic                                ready_in,
   output logic                                sop_out,
   output logic                                eop_out
);

   localparam int               OFF_W       = (CHUNK_QW_NBITS > 0) ? CHUNK_QW_NBITS : 1;
   localparam logic [OFF_W-1:0] LAST_OFFSET = OFF_W'((1 << CHUNK_QW_NBITS) - 1);

   C2FReaderState              state;
   C2FReaderState              stateNext;
   logic [NUMCHUNKS_NBITS-1:0] rdPtr;
   logic [OFF_W-1:0]           issueOffset;
   logic [OFF_W-1:0]           offsetNext;
   logic                       issueEn;
   logic                       inflight;
   logic                       inflightSop;
   logic                       inflightEop;
   logic                       dtAck;
   logic [1:0]                 occupancy;
   C2FBeat                     head;
   C2FBeat                     pushBeat;
   logic                       pop;
   logic                       ringEmpty;
   logic                       bufferRoom;
   logic                       chunkDone;
   logic [2:0]                 credit;

   assign valid_out  = (occupancy != 2'd0);
   assign pop        = valid_out && ready_in;
   assign ringEmpty  = (rdPtr == wrPtr_in);
   assign credit     = {1'b0, occupancy} + {2'b00, inflight} - {2'b00, pop};
   assign bufferRoom = (credit < 3'd2);
   assign chunkDone  = (state == S_DRAIN) && pop && head.eop;

   assign data_out  = head.data;
   assign sop_out   = valid_out && head.sop;
   assign eop_out   = valid_out && head.eop;
   assign rdPtr_out = rdPtr;
   assign dtAck_out = dtAck;

   assign pushBeat = '{data: ramData_in, sop: inflightSop, eop: inflightEop};

   generate
      if (CHUNK_QW_NBITS == 0) begin : gSingleQw
         assign ramAddr_out = rdPtr;
      end else begin : gMultiQw
         assign ramAddr_out = {rdPtr, issueOffset};
      end
   endgenerate

   c2f_skid2 skid (
      .clk_in    (clk_in),
      .rstn_in   (rstn_in),
      .push      (inflight),
      .pushBeat  (pushBeat),
      .pop       (pop),
      .occupancy (occupancy),
      .head      (head)
   );

   // Next-state and read-issue decision; the offset wraps to zero after the last qword
   always_comb begin
      stateNext  = state;
      issueEn    = 1'b0;
      offsetNext = issueOffset;
      case (state)
         S_IDLE: begin
            if (enable_in && !ringEmpty && bufferRoom) begin
               issueEn    = 1'b1;
               offsetNext = (issueOffset == LAST_OFFSET) ? '0 : issueOffset + 1'b1;
               stateNext  = (issueOffset == LAST_OFFSET) ? S_DRAIN : S_STREAM;
            end
         end
         S_STREAM: begin
            if (bufferRoom) begin
               issueEn    = 1'b1;
               offsetNext = (issueOffset == LAST_OFFSET) ? '0 : issueOffset + 1'b1;
               if (issueOffset == LAST_OFFSET) begin
                  stateNext = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (chunkDone) begin
               stateNext = S_IDLE;
            end
         end
         default: begin
            stateNext = S_IDLE;
         end
      endcase
   end

   // State, issue offset, ring read pointer and the chunk-consumed acknowledge
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state       <= S_IDLE;
         issueOffset <= '0;
         rdPtr       <= '0;
         dtAck       <= 1'b0;
      end else begin
         state       <= stateNext;
         issueOffset <= offsetNext;
         dtAck       <= chunkDone;
         if (chunkDone) begin
            rdPtr <= rdPtr + 1'b1;
         end
      end
   end

   // Remember which reads are in flight so their data is tagged when it returns
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         inflight    <= 1'b0;
         inflightSop <= 1'b0;
         inflightEop <= 1'b0;
      end else begin
         inflight    <= issueEn;
         inflightSop <= issueEn && (issueOffset == '0);
         inflightEop <= issueEn && (issueOffset == LAST_OFFSET);
      end
   end

endmodule

// File: tb/tb_c2f_chunk_reader.sv
// Self-checking bench: random RAM contents, expected stream built from ring order.
module tb_c2f_chunk_reader;

   localparam int QW    = 4;
   localparam int NC    = 2;
   localparam int BEATS = 1 << QW;
   localparam int NCH   = 1 << NC;

   logic              clk_in    = 1'b0;
   logic              rstn_in   = 1'b0;
   logic              enable_in = 1'b0;
   logic              ready_in  = 1'b0;
   logic [NC-1:0]     wrPtr_in  = '0;
   logic [NC-1:0]     rdPtr_out;
   logic              dtAck_out;
   logic [NC+QW-1:0]  ramAddr_out;
   logic [63:0]       ramData_in;
   logic [63:0]       data_out;
   logic              valid_out;
   logic              sop_out;
   logic              eop_out;

   logic [63:0] ram [NCH*BEATS];

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] expData[$];
   logic        expSop[$];
   logic        expEop[$];
   logic [63:0] obsData[$];
   logic        obsSop[$];
   logic        obsEop[$];
   int          obsCycle[$];
   int          ackCycle[$];
   int          ackPtr[$];
   int          cycleIdx;
   int          stallErrors;
   logic        prevStall;
   logic [63:0] prevData;
   logic        prevSop;
   logic        prevEop;

   c2f_chunk_reader dut (
      .clk_in      (clk_in),
      .rstn_in     (rstn_in),
      .enable_in   (enable_in),
      .wrPtr_in    (wrPtr_in),
      .rdPtr_out   (rdPtr_out),
      .dtAck_out   (dtAck_out),
      .ramAddr_out (ramAddr_out),
      .ramData_in  (ramData_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .ready_in    (ready_in),
      .sop_out     (sop_out),
      .eop_out     (eop_out)
   );

   always #5 clk_in = ~clk_in;

   // Synchronous RAM: data appears one cycle after the address
   always @(posedge clk_in) ramData_in <= ram[ramAddr_out];

   task automatic clearObs();
      expData.delete(); expSop.delete(); expEop.delete();
      obsData.delete(); obsSop.delete(); obsEop.delete(); obsCycle.delete();
      ackCycle.delete(); ackPtr.delete();
      cycleIdx = 0; stallErrors = 0; prevStall = 1'b0;
   endtask

   // Reference model: a chunk is simply its slot's qwords in address order
   task automatic expectChunk(input int c);
      for (int i = 0; i < BEATS; i++) begin
         expData.push_back(ram[c*BEATS + i]);
         expSop.push_back(i == 0);
         expEop.push_back(i == BEATS-1);
      end
   endtask

   // Runs cycles, drives ready, records pops/acks and stall-stability violations
   task automatic stepCycles(input int maxCycles, input int readyMode, input int stopAtPops);
      for (int c = 0; c < maxCycles; c++) begin
         @(negedge clk_in);
         case (readyMode)
            1:       ready_in = ((cycleIdx % 4) == 0) || ((cycleIdx % 4) == 3);
            2:       ready_in = ($urandom_range(0, 1) == 1);
            default: ready_in = 1'b1;
         endcase
         if (prevStall && (!valid_out || data_out !== prevData ||
                           sop_out !== prevSop || eop_out !== prevEop)) stallErrors++;
         prevStall = valid_out && !ready_in;
         prevData  = data_out;
         prevSop   = sop_out;
         prevEop   = eop_out;
         if (valid_out && ready_in) begin
            obsData.push_back(data_out);
            obsSop.push_back(sop_out);
            obsEop.push_back(eop_out);
            obsCycle.push_back(cycleIdx);
         end
         if (dtAck_out) begin
            ackCycle.push_back(cycleIdx);
            ackPtr.push_back(int'(rdPtr_out));
         end
         cycleIdx++;
         if (stopAtPops > 0 && obsData.size() >= stopAtPops) break;
      end
   endtask

   task automatic test_reset();
      rstn_in = 1'b0; enable_in = 1'b0; ready_in = 1'b0; wrPtr_in = '0;
      repeat (3) @(negedge clk_in);
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset valid: got %b want 0", valid_out); end
      vectors++; if (sop_out !== 1'b0 || eop_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset sop/eop: got %b/%b want 0/0", sop_out, eop_out); end
      vectors++; if (dtAck_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset dtAck: got %b want 0", dtAck_out); end
      vectors++; if (rdPtr_out !== '0) begin miscompares++; $display("[TB] FAIL reset rdPtr: got %0d want 0", rdPtr_out); end
      vectors++; if (ramAddr_out !== '0) begin miscompares++; $display("[TB] FAIL reset ramAddr: got %0d want 0", ramAddr_out); end
      rstn_in = 1'b1;
      repeat (4) @(negedge clk_in);
      vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("[TB] FAIL idle after reset valid: got %b want 0", valid_out); end
   endtask

   task automatic test_basic_chunk();
      int holes;
      clearObs(); expectChunk(0);
      enable_in = 1'b1; ready_in = 1'b1; wrPtr_in = 2'd1;
      stepCycles(60, 0, 0);
      vectors++; if (obsData.size() != BEATS) begin miscompares++; $display("[TB] FAIL basic beat count: got %0d want %0d", obsData.size(), BEATS); end
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
         vectors++;
         if (obsData[i] !== expData[i] || obsSop[i] !== expSop[i] || obsEop[i] !== expEop[i]) begin
            miscompares++;
            $display("[TB] FAIL basic beat %0d: got %h sop=%b eop=%b want %h sop=%b eop=%b",
                     i, obsData[i], obsSop[i], obsEop[i], expData[i], expSop[i], expEop[i]);
         end
      end
      if (obsCycle.size() > 0) begin
         vectors++; if (obsCycle[0] != 1) begin miscompares++; $display("[TB] FAIL basic first-beat latency: got cycle %0d want 1", obsCycle[0]); end
         holes = 0;
         for (int i = 1; i < obsCycle.size(); i++) if (obsCycle[i] != obsCycle[0] + i) holes++;
         vectors++; if (holes != 0) begin miscompares++; $display("[TB] FAIL basic consecutive beats: got %0d gaps want 0", holes); end
      end
      vectors++; if (ackCycle.size() != 1) begin miscompares++; $display("[TB] FAIL basic ack count: got %0d want 1", ackCycle.size()); end
      if (ackCycle.size() > 0 && obsCycle.size() > 0) begin
         vectors++; if (ackCycle[0] != obsCycle[obsCycle.size()-1] + 1) begin miscompares++; $display("[TB] FAIL basic ack timing: got cycle %0d want %0d", ackCycle[0], obsCycle[obsCycle.size()-1] + 1); end
         vectors++; if (ackPtr[0] != 1) begin miscompares++; $display("[TB] FAIL basic rdPtr at ack: got %0d want 1", ackPtr[0]); end
      end
      vectors++; if (rdPtr_out !== 2'd1) begin miscompares++; $display("[TB] FAIL basic final rdPtr: got %0d want 1", rdPtr_out); end
   endtask

   task automatic test_backpressure();
      clearObs(); expectChunk(1);
      enable_in = 1'b1; ready_in = 1'b1; wrPtr_in = 2'd2;
      stepCycles(120, 1, 0);
      vectors++; if (obsData.size() != BEATS) begin miscompares++; $display("[TB] FAIL backpressure beat count: got %0d want %0d", obsData.size(), BEATS); end
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
         vectors++;
         if (obsData[i] !== expData[i] || obsSop[i] !== expSop[i] || obsEop[i] !== expEop[i]) begin
            miscompares++;
            $display("[TB] FAIL backpressure beat %0d: got %h sop=%b eop=%b want %h sop=%b eop=%b",
                     i, obsData[i], obsSop[i], obsEop[i], expData[i], expSop[i], expEop[i]);
         end
      end
      vectors++; if (stallErrors != 0) begin miscompares++; $display("[TB] FAIL backpressure stall stability: got %0d violations want 0", stallErrors); end
      vectors++; if (ackCycle.size() != 1) begin miscompares++; $display("[TB] FAIL backpressure ack count: got %0d want 1", ackCycle.size()); end
      vectors++; if (rdPtr_out !== 2'd2) begin miscompares++; $display("[TB] FAIL backpressure final rdPtr: got %0d want 2", rdPtr_out); end
   endtask

   task automatic test_empty_idle();
      int badCycles;
      logic [NC+QW-1:0] expAddr;
      expAddr = (NC+QW)'(2*BEATS);
      badCycles = 0;
      enable_in = 1'b1; ready_in = 1'b1; wrPtr_in = 2'd2;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_in);
         if (valid_out !== 1'b0 || ramAddr_out !== expAddr || dtAck_out !== 1'b0) badCycles++;
      end
      vectors++; if (badCycles != 0) begin miscompares++; $display("[TB] FAIL empty idle: got %0d active cycles (addr %0d) want 0 (addr %0d)", badCycles, ramAddr_out, expAddr); end
   endtask

   task automatic test_random_ready();
      clearObs(); expectChunk(2);
      wrPtr_in = 2'd3;
      stepCycles(300, 2, 0);
      vectors++; if (obsData.size() != BEATS) begin miscompares++; $display("[TB] FAIL random beat count: got %0d want %0d", obsData.size(), BEATS); end
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
         vectors++;
         if (obsData[i] !== expData[i] || obsSop[i] !== expSop[i] || obsEop[i] !== expEop[i]) begin
            miscompares++;
            $display("[TB] FAIL random beat %0d: got %h sop=%b eop=%b want %h sop=%b eop=%b",
                     i, obsData[i], obsSop[i], obsEop[i], expData[i], expSop[i], expEop[i]);
         end
      end
      vectors++; if (stallErrors != 0) begin miscompares++; $display("[TB] FAIL random stall stability: got %0d violations want 0", stallErrors); end
      vectors++; if (rdPtr_out !== 2'd3) begin miscompares++; $display("[TB] FAIL random final rdPtr: got %0d want 3", rdPtr_out); end
   endtask

   task automatic test_back_to_back();
      clearObs(); expectChunk(3); expectChunk(0);
      ready_in = 1'b1; wrPtr_in = 2'd1;
      stepCycles(100, 0, 0);
      vectors++; if (obsData.size() != 2*BEATS) begin miscompares++; $display("[TB] FAIL wrap beat count: got %0d want %0d", obsData.size(), 2*BEATS); end
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
         vectors++;
         if (obsData[i] !== expData[i] || obsSop[i] !== expSop[i] || obsEop[i] !== expEop[i]) begin
            miscompares++;
            $display("[TB] FAIL wrap beat %0d: got %h sop=%b eop=%b want %h sop=%b eop=%b",
                     i, obsData[i], obsSop[i], obsEop[i], expData[i], expSop[i], expEop[i]);
         end
      end
      if (obsCycle.size() > BEATS) begin
         vectors++; if (obsCycle[BEATS] - obsCycle[BEATS-1] > 4) begin miscompares++; $display("[TB] FAIL wrap inter-chunk gap: got %0d idle cycles want <= 3", obsCycle[BEATS] - obsCycle[BEATS-1] - 1); end
      end
      vectors++; if (ackPtr.size() != 2) begin miscompares++; $display("[TB] FAIL wrap ack count: got %0d want 2", ackPtr.size()); end
      if (ackPtr.size() == 2) begin
         vectors++; if (ackPtr[0] != 0 || ackPtr[1] != 1) begin miscompares++; $display("[TB] FAIL wrap rdPtr sequence: got %0d,%0d want 0,1", ackPtr[0], ackPtr[1]); end
      end
      vectors++; if (rdPtr_out !== 2'd1) begin miscompares++; $display("[TB] FAIL wrap final rdPtr: got %0d want 1", rdPtr_out); end
   endtask

   task automatic test_enable_drop();
      logic [NC+QW-1:0] expAddr;
      expAddr = (NC+QW)'(2*BEATS);
      clearObs(); expectChunk(1);
      enable_in = 1'b1; ready_in = 1'b1; wrPtr_in = 2'd3;
      stepCycles(40, 0, 5);
      vectors++; if (obsData.size() != 5) begin miscompares++; $display("[TB] FAIL enable-drop reach beat 5: got %0d beats want 5", obsData.size()); end
      enable_in = 1'b0;
      stepCycles(60, 0, 0);
      vectors++; if (obsData.size() != BEATS) begin miscompares++; $display("[TB] FAIL enable-drop beat count: got %0d want %0d", obsData.size(), BEATS); end
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
         vectors++;
         if (obsData[i] !== expData[i] || obsSop[i] !== expSop[i] || obsEop[i] !== expEop[i]) begin
            miscompares++;
            $display("[TB] FAIL enable-drop beat %0d: got %h want %h", i, obsData[i], expData[i]);
         end
      end
      vectors++; if (rdPtr_out !== 2'd2 || valid_out !== 1'b0 || ramAddr_out !== expAddr) begin miscompares++; $display("[TB] FAIL enable-drop held: got rdPtr=%0d valid=%b addr=%0d want 2/0/%0d", rdPtr_out, valid_out, ramAddr_out, expAddr); end
      clearObs(); expectChunk(2);
      enable_in = 1'b1;
      stepCycles(60, 0, 0);
      vectors++; if (obsData.size() != BEATS) begin miscompares++; $display("[TB] FAIL enable-resume beat count: got %0d want %0d", obsData.size(), BEATS); end
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
         vectors++;
         if (obsData[i] !== expData[i] || obsSop[i] !== expSop[i] || obsEop[i] !== expEop[i]) begin
            miscompares++;
            $display("[TB] FAIL enable-resume beat %0d: got %h want %h", i, obsData[i], expData[i]);
         end
      end
      vectors++; if (rdPtr_out !== 2'd3) begin miscompares++; $display("[TB] FAIL enable-resume final rdPtr: got %0d want 3", rdPtr_out); end
   endtask

   task automatic test_reset_mid();
      clearObs(); expectChunk(3);
      enable_in = 1'b1; ready_in = 1'b1; wrPtr_in = 2'd0;
      stepCycles(40, 0, 7);
      vectors++; if (obsData.size() != 7) begin miscompares++; $display("[TB] FAIL reset-mid reach beat 7: got %0d beats want 7", obsData.size()); end
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
         vectors++;
         if (obsData[i] !== expData[i] || obsSop[i] !== expSop[i] || obsEop[i] !== expEop[i]) begin
            miscompares++;
            $display("[TB] FAIL reset-mid pre beat %0d: got %h want %h", i, obsData[i], expData[i]);
         end
      end
      rstn_in = 1'b0;
      #1;
      vectors++; if (valid_out !== 1'b0 || dtAck_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset-mid async: got valid=%b dtAck=%b want 0/0", valid_out, dtAck_out); end
      vectors++; if (rdPtr_out !== 2'd0) begin miscompares++; $display("[TB] FAIL reset-mid rdPtr: got %0d want 0", rdPtr_out); end
      wrPtr_in = 2'd1;
      repeat (2) @(negedge clk_in);
      rstn_in = 1'b1;
      clearObs(); expectChunk(0);
      stepCycles(60, 0, 0);
      vectors++; if (obsData.size() != BEATS) begin miscompares++; $display("[TB] FAIL reset-mid restart beat count: got %0d want %0d", obsData.size(), BEATS); end
      for (int i = 0; i < obsData.size() && i < expData.size(); i++) begin
         vectors++;
         if (obsData[i] !== expData[i] || obsSop[i] !== expSop[i] || obsEop[i] !== expEop[i]) begin
            miscompares++;
            $display("[TB] FAIL reset-mid restart beat %0d: got %h want %h", i, obsData[i], expData[i]);
         end
      end
      vectors++; if (rdPtr_out !== 2'd1) begin miscompares++; $display("[TB] FAIL reset-mid final rdPtr: got %0d want 1", rdPtr_out); end
   endtask

   initial begin
      for (int i = 0; i < NCH*BEATS; i++) ram[i] = {$urandom(), $urandom()};
      clearObs();
      test_reset();
      test_basic_chunk();
      test_backpressure();
      test_empty_idle();
      test_random_ready();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard stop in case anything stalls the sequence
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, vectors=%0d", vectors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
